mem_router: RTL and testbench

MEM_ROUTER -- requirements
Module: mem_router

---
 rtl/mem_router.sv | 180 ++++++++++++++++++
 tb/tb_mem_router.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_router.sv
// mem_router: decodes CPU memory accesses onto N_TGT targets. Fixed targets
// are single-cycle BRAMs (data returns the next cycle, no stall); wait targets
// hold the core until they raise tgt_ack. Unmapped accesses return a one-cycle
// bus-error pulse.
// Optional feature: define MEM_ROUTER_TIMEOUT_EN to abandon a wait target that
// fails to ack within TIMEOUT_CYCLES WAIT cycles (reported as a bus error).
module mem_router #(
    parameter int                           XLEN           = 32,
    parameter int                           N_TGT          = 4,
    parameter int                           REGION_BITS    = 4,
    parameter logic [N_TGT*REGION_BITS-1:0] TGT_BASE       = {4'h3, 4'h2, 4'h1, 4'h4},
    parameter logic [N_TGT-1:0]             TGT_WAIT       = 4'b1000,
    parameter int                           TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [3:0]            cpu_we,
    input  logic [XLEN-1:0]       cpu_adr,
    input  logic [XLEN-1:0]       cpu_wdata,
    output logic [XLEN-1:0]       cpu_rdata,
    output logic                  cpu_stall,
    output logic                  cpu_err,
    output logic [N_TGT-1:0]      tgt_sel,
    output logic [4*N_TGT-1:0]    tgt_wea,
    output logic [XLEN-1:0]       tgt_adr,
    output logic [XLEN-1:0]       tgt_wdata,
    input  logic [XLEN*N_TGT-1:0] tgt_rdata,
    input  logic [N_TGT-1:0]      tgt_ack
);

    localparam int IDX_W = (N_TGT > 1) ? $clog2(N_TGT) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic             r_fix_valid;
    logic [IDX_W-1:0] r_fix_idx;
    logic             r_unmap_err;
    logic [IDX_W-1:0] r_hold_idx;
    logic [XLEN-1:0]  r_hold_adr;
    logic [XLEN-1:0]  r_hold_wdata;
    logic [3:0]       r_hold_we;
    logic [XLEN-1:0]  r_resp;

    logic             w_hit;
    logic [IDX_W-1:0] w_hit_idx;
    logic             w_accept;
    logic             w_acc_hit;
    logic             w_acc_wait;
    logic             w_acc_fix;
    logic             w_acc_unmap;
    logic             w_in_wait;
    logic             w_ack;
    logic             w_timeout;

    // Region decode: scan downward so the lowest matching index is kept.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if (cpu_adr[XLEN-1 -: REGION_BITS] == TGT_BASE[i*REGION_BITS +: REGION_BITS]) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    // IDLE and DONE both accept a new request; reset blocks acceptance.
    assign w_accept    = rst && cpu_req && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_acc_hit   = w_accept && w_hit;
    assign w_acc_wait  = w_acc_hit && TGT_WAIT[w_hit_idx];
    assign w_acc_fix   = w_acc_hit && !TGT_WAIT[w_hit_idx];
    assign w_acc_unmap = w_accept && !w_hit;
    assign w_in_wait   = (r_state == S_WAIT);
    // Only the ack of the held target counts, and only while waiting.
    assign w_ack       = w_in_wait && tgt_ack[r_hold_idx];

`ifdef MEM_ROUTER_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

    logic [CNT_W-1:0] r_count;

    assign w_timeout = w_in_wait && !w_ack && (r_count == CNT_W'(TIMEOUT_CYCLES));

    // Timeout counter: cleared on entry to WAIT, counts every WAIT cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (w_acc_wait) begin
            r_count <= '0;
        end else if (w_in_wait) begin
            r_count <= r_count + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Target-side drive: live CPU request in IDLE/DONE, holding registers in WAIT.
    always_comb begin
        tgt_sel   = '0;
        tgt_wea   = '0;
        tgt_adr   = cpu_adr;
        tgt_wdata = cpu_wdata;
        if (w_in_wait) begin
            tgt_adr   = r_hold_adr;
            tgt_wdata = r_hold_wdata;
            if (!w_timeout) begin
                tgt_sel[r_hold_idx]                 = 1'b1;
                tgt_wea[int'(r_hold_idx)*4 +: 4]    = r_hold_we;
            end
        end else if (w_acc_hit) begin
            tgt_sel[w_hit_idx]              = 1'b1;
            tgt_wea[int'(w_hit_idx)*4 +: 4] = cpu_we;
        end
    end

    // CPU-side response: fixed-target data, wait-target response, or zero.
    always_comb begin
        cpu_stall = w_acc_wait || (w_in_wait && !w_ack && !w_timeout);
        cpu_err   = r_unmap_err || w_timeout;
        cpu_rdata = '0;
        if (r_fix_valid) begin
            cpu_rdata = tgt_rdata[int'(r_fix_idx)*XLEN +: XLEN];
        end else if (r_state == S_DONE) begin
            cpu_rdata = r_resp;
        end
    end

    // FSM and one-cycle response flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: sequential state is written with <= so every register samples pre-edge values.
            r_state     <= S_IDLE;
            r_fix_valid <= 1'b0;
            r_fix_idx   <= '0;
            r_unmap_err <= 1'b0;
        end else begin
            r_fix_valid <= w_acc_fix;
            r_unmap_err <= w_acc_unmap;
            if (w_acc_fix) begin
                r_fix_idx <= w_hit_idx;
            end
            case (r_state)
                S_IDLE, S_DONE: r_state <= w_acc_wait ? S_WAIT : S_IDLE;
                S_WAIT:         if (w_ack || w_timeout) r_state <= S_DONE;
                default:        r_state <= S_IDLE;
            endcase
        end
    end

    // Holding and response registers for wait-target transactions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hold_idx   <= '0;
            r_hold_adr   <= '0;
            r_hold_wdata <= '0;
            r_hold_we    <= '0;
            r_resp       <= '0;
        end else begin
            if (w_acc_wait) begin
                r_hold_idx   <= w_hit_idx;
                r_hold_adr   <= cpu_adr;
                r_hold_wdata <= cpu_wdata;
                r_hold_we    <= cpu_we;
            end
            if (w_ack) begin
                r_resp <= tgt_rdata[int'(r_hold_idx)*XLEN +: XLEN];
            end else if (w_timeout) begin
                r_resp <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_router.sv
// Directed testbench for mem_router. Region map used here: target i decodes
// region i+1 (0x1.., 0x2.., 0x3.., 0x4..); target 3 is the handshake target.
// Build with MEM_ROUTER_TIMEOUT_EN to also exercise the timeout path
// (TIMEOUT_CYCLES overridden to 4).
module tb_mem_router;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cpu_req = 1'b0;
    logic [3:0]   cpu_we = 4'h0;
    logic [31:0]  cpu_adr = 32'h0;
    logic [31:0]  cpu_wdata = 32'h0;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic         cpu_err;
    logic [3:0]   tgt_sel;
    logic [15:0]  tgt_wea;
    logic [31:0]  tgt_adr;
    logic [31:0]  tgt_wdata;
    logic [127:0] tgt_rdata = 128'h0;
    logic [3:0]   tgt_ack = 4'h0;

    int errors = 0;
    int checks = 0;

    mem_router #(
        .XLEN(32), .N_TGT(4), .REGION_BITS(4),
        .TGT_BASE(16'h4321), .TGT_WAIT(4'b1000)
`ifdef MEM_ROUTER_TIMEOUT_EN
        , .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .cpu_err(cpu_err), .tgt_sel(tgt_sel),
        .tgt_wea(tgt_wea), .tgt_adr(tgt_adr), .tgt_wdata(tgt_wdata),
        .tgt_rdata(tgt_rdata), .tgt_ack(tgt_ack)
    );

    always #5 clk = ~clk;

    // Inputs change just after the active edge; checks happen on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cpu_req = 1'b0;
        rst = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", cpu_stall); end
        checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", cpu_err); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", cpu_rdata); end
        checks++; if (tgt_sel !== 4'h0) begin errors++; $display("FAIL rst_sel: got %b expected 0000", tgt_sel); end
        checks++; if (tgt_wea !== 16'h0) begin errors++; $display("FAIL rst_wea: got %h expected 0000", tgt_wea); end
        next_cycle();
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_fixed_load();
        cpu_req = 1'b1; cpu_we = 4'h0; cpu_adr = 32'h1000_0010;
        @(negedge clk);
        checks++; if (tgt_sel !== 4'b0001) begin errors++; $display("FAIL fix_sel: got %b expected 0001", tgt_sel); end
        checks++; if (tgt_adr !== 32'h1000_0010) begin errors++; $display("FAIL fix_adr: got %h expected 10000010", tgt_adr); end
        checks++; if (tgt_wea !== 16'h0) begin errors++; $display("FAIL fix_wea: got %h expected 0000", tgt_wea); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL fix_stall0: got %b expected 0", cpu_stall); end
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fix_rdata: got %h expected deadbeef", cpu_rdata); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL fix_stall1: got %b expected 0", cpu_stall); end
        checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL fix_err: got %b expected 0", cpu_err); end
        next_cycle();
        @(negedge clk);
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL fix_rdata_idle: got %h expected 0", cpu_rdata); end
    endtask

    task automatic test_fixed_store();
        next_cycle();
        cpu_req = 1'b1; cpu_we = 4'b0011; cpu_adr = 32'h2000_0004; cpu_wdata = 32'h1234_5678;
        @(negedge clk);
        checks++; if (tgt_wea !== 16'h0030) begin errors++; $display("FAIL st_wea: got %h expected 0030", tgt_wea); end
        checks++; if (tgt_sel !== 4'b0010) begin errors++; $display("FAIL st_sel: got %b expected 0010", tgt_sel); end
        checks++; if (tgt_wdata !== 32'h1234_5678) begin errors++; $display("FAIL st_wdata: got %h expected 12345678", tgt_wdata); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL st_stall: got %b expected 0", cpu_stall); end
        next_cycle();
        cpu_req = 1'b0; cpu_we = 4'h0;
    endtask

    task automatic test_back_to_back();
        next_cycle();
        cpu_req = 1'b1; cpu_adr = 32'h1000_0000;
        @(negedge clk);
        checks++; if (tgt_sel !== 4'b0001) begin errors++; $display("FAIL b2b_sel0: got %b expected 0001", tgt_sel); end
        next_cycle();
        cpu_adr = 32'h3000_0000;
        @(negedge clk);
        checks++; if (tgt_sel !== 4'b0100) begin errors++; $display("FAIL b2b_sel1: got %b expected 0100", tgt_sel); end
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_rdata0: got %h expected deadbeef", cpu_rdata); end
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (cpu_rdata !== 32'h2222_2222) begin errors++; $display("FAIL b2b_rdata1: got %h expected 22222222", cpu_rdata); end
        next_cycle();
    endtask

    task automatic test_wait_load();
        int stall_cycles;
        stall_cycles = 0;
        tgt_rdata[127:96] = 32'h0000_00A5;
        cpu_req = 1'b1; cpu_we = 4'h0; cpu_adr = 32'h4000_0008;
        @(negedge clk);
        checks++; if (tgt_sel !== 4'b1000) begin errors++; $display("FAIL wt_issue_sel: got %b expected 1000", tgt_sel); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL wt_issue_stall: got %b expected 1", cpu_stall); end
        if (cpu_stall === 1'b1) stall_cycles++;
        next_cycle();
        // Wiggle CPU inputs and ack a non-selected target: all must be ignored.
        cpu_adr = 32'h1000_0000; cpu_we = 4'hF; tgt_ack = 4'b0001;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (cpu_stall === 1'b1) stall_cycles++;
            checks++; if (tgt_sel !== 4'b1000) begin errors++; $display("FAIL wt_hold_sel c%0d: got %b expected 1000", c, tgt_sel); end
            checks++; if (tgt_adr !== 32'h4000_0008) begin errors++; $display("FAIL wt_hold_adr c%0d: got %h expected 40000008", c, tgt_adr); end
            next_cycle();
        end
        tgt_ack = 4'b1001;
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL wt_ack_stall: got %b expected 0", cpu_stall); end
        checks++; if (stall_cycles !== 6) begin errors++; $display("FAIL wt_stall_count: got %0d expected 6", stall_cycles); end
        next_cycle();
        cpu_req = 1'b0; cpu_we = 4'h0; tgt_ack = 4'h0; tgt_rdata[127:96] = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if (cpu_rdata !== 32'h0000_00A5) begin errors++; $display("FAIL wt_done_rdata: got %h expected 000000a5", cpu_rdata); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL wt_done_stall: got %b expected 0", cpu_stall); end
        checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL wt_done_err: got %b expected 0", cpu_err); end
        next_cycle();
        @(negedge clk);
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL wt_after_rdata: got %h expected 0", cpu_rdata); end
        next_cycle();
    endtask

    task automatic test_unmapped();
        cpu_req = 1'b1; cpu_we = 4'h0; cpu_adr = 32'hF000_0000;
        @(negedge clk);
        checks++; if (tgt_sel !== 4'h0) begin errors++; $display("FAIL um_sel: got %b expected 0000", tgt_sel); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL um_stall: got %b expected 0", cpu_stall); end
        checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL um_err_early: got %b expected 0", cpu_err); end
        next_cycle();
        cpu_we = 4'hF; cpu_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        checks++; if (cpu_err !== 1'b1) begin errors++; $display("FAIL um_err: got %b expected 1", cpu_err); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL um_rdata: got %h expected 0", cpu_rdata); end
        checks++; if (tgt_wea !== 16'h0) begin errors++; $display("FAIL um_st_wea: got %h expected 0000", tgt_wea); end
        checks++; if (tgt_sel !== 4'h0) begin errors++; $display("FAIL um_st_sel: got %b expected 0000", tgt_sel); end
        next_cycle();
        cpu_req = 1'b0; cpu_we = 4'h0;
        @(negedge clk);
        checks++; if (cpu_err !== 1'b1) begin errors++; $display("FAIL um_st_err: got %b expected 1", cpu_err); end
        next_cycle();
        @(negedge clk);
        checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL um_err_clear: got %b expected 0", cpu_err); end
    endtask

    task automatic test_ack_in_idle();
        tgt_ack = 4'hF;
        next_cycle();
        @(negedge clk);
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL idle_ack_rdata: got %h expected 0", cpu_rdata); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL idle_ack_stall: got %b expected 0", cpu_stall); end
        tgt_ack = 4'h0;
        next_cycle();
    endtask

    task automatic test_reset_in_wait();
        cpu_req = 1'b1; cpu_we = 4'h0; cpu_adr = 32'h4000_0000;
        next_cycle();
        cpu_req = 1'b0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rw_stall_pre: got %b expected 1", cpu_stall); end
        next_cycle();
        rst = 1'b1; tgt_ack = 4'b1000; tgt_rdata[127:96] = 32'h0000_0077;
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rw_stall: got %b expected 0", cpu_stall); end
        checks++; if (tgt_sel !== 4'h0) begin errors++; $display("FAIL rw_sel: got %b expected 0000", tgt_sel); end
        next_cycle();
        tgt_ack = 4'h0;
        @(negedge clk);
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rw_late_ack_rdata: got %h expected 0", cpu_rdata); end
        checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL rw_err: got %b expected 0", cpu_err); end
        next_cycle();
        cpu_req = 1'b1; cpu_adr = 32'h2000_0000;
        @(negedge clk);
        checks++; if (tgt_sel !== 4'b0010) begin errors++; $display("FAIL rw_next_sel: got %b expected 0010", tgt_sel); end
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (cpu_rdata !== 32'h1111_1111) begin errors++; $display("FAIL rw_next_rdata: got %h expected 11111111", cpu_rdata); end
        next_cycle();
    endtask

`ifdef MEM_ROUTER_TIMEOUT_EN
    task automatic test_timeout();
        int  stall_cycles;
        bit  released;
        stall_cycles = 0;
        released = 1'b0;
        cpu_req = 1'b1; cpu_we = 4'h0; cpu_adr = 32'h4000_0000;
        for (int c = 0; c < 20 && !released; c++) begin
            @(negedge clk);
            if (cpu_stall === 1'b1) begin
                stall_cycles++;
                next_cycle();
                cpu_req = 1'b0;
            end else begin
                released = 1'b1;
            end
        end
        checks++; if (released !== 1'b1) begin errors++; $display("FAIL to_release: stall never dropped"); end
        checks++; if (stall_cycles !== 5) begin errors++; $display("FAIL to_stall_count: got %0d expected 5", stall_cycles); end
        checks++; if (cpu_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", cpu_err); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h expected 0", cpu_rdata); end
        checks++; if (tgt_sel !== 4'h0) begin errors++; $display("FAIL to_sel: got %b expected 0000", tgt_sel); end
        next_cycle();
        @(negedge clk);
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL to_done_rdata: got %h expected 0", cpu_rdata); end
        checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL to_done_err: got %b expected 0", cpu_err); end
        next_cycle();
        cpu_req = 1'b1; cpu_adr = 32'h1000_0000;
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL to_next_stall: got %b expected 0", cpu_stall); end
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_next_rdata: got %h expected deadbeef", cpu_rdata); end
        next_cycle();
    endtask
`endif

    initial begin
        tgt_rdata[31:0]   = 32'hDEAD_BEEF;
        tgt_rdata[63:32]  = 32'h1111_1111;
        tgt_rdata[95:64]  = 32'h2222_2222;
        tgt_rdata[127:96] = 32'h0;
        test_reset();
        test_fixed_load();
        test_fixed_store();
        test_back_to_back();
        test_wait_load();
        test_unmapped();
        test_ack_in_idle();
        test_reset_in_wait();
`ifdef MEM_ROUTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
